// File: rtl/rat_seq_irq_pkg.sv
// Shared types and constants for the RAT sequencer with prioritised interrupts.
// No logic lives here; pure declarations.
// Imported by the interface, the priority sub-module and the sequencer top.
package rat_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_IOWAIT = 3'd3,
    ST_INTRPT = 3'd4
  } seq_state_t;

  localparam logic [9:0] RAT_DEFAULT_VEC = 10'h3FF;
  localparam int         RAT_MAX_IRQ     = 16;
  // Winner index width is sized for the largest legal source count so it
  // never collapses to zero bits when NUM_IRQ is 1.
  localparam int         RAT_IDX_W       = $clog2(RAT_MAX_IRQ);

endpackage

// File: rtl/rat_seq_irq_if.sv
// Control bundle between the sequencer and the decoder/datapath.
// master = sequencer (drives strobes, vector, ack, flags, state).
// slave  = decoder/datapath side (drives IRQs, flag ops, IO handshake).
interface rat_seq_irq_if #(
  parameter int NUM_IRQ = 4,
  parameter int PC_W    = 10
);

  logic [NUM_IRQ-1:0]   IRQ;
  logic                 I_SET;
  logic                 I_CLR;
  logic                 IO_REQ;
  logic                 IO_RDY;
  logic                 PC_RST;
  logic                 PC_INC;
  logic                 EXEC_EN;
  logic                 INTR_ACTIVE;
  logic [PC_W-1:0]      VECTOR;
  logic [NUM_IRQ-1:0]   IRQ_ACK;
  logic                 I_FLAG;
  logic                 IO_TIMEOUT;
  rat_pkg::seq_state_t  STATE;

  modport master (
    input  IRQ, I_SET, I_CLR, IO_REQ, IO_RDY,
    output PC_RST, PC_INC, EXEC_EN, INTR_ACTIVE, VECTOR, IRQ_ACK,
           I_FLAG, IO_TIMEOUT, STATE
  );

  modport slave (
    output IRQ, I_SET, I_CLR, IO_REQ, IO_RDY,
    input  PC_RST, PC_INC, EXEC_EN, INTR_ACTIVE, VECTOR, IRQ_ACK,
           I_FLAG, IO_TIMEOUT, STATE
  );

endinterface

// File: rtl/rat_irq_prio.sv
// Interrupt front end: edge detect, edge pending latches, lowest-index priority pick.
// Latency: level sources pend combinationally; edge sources pend one clock after the edge.
// No backpressure: an edge pending bit holds until acknowledged; a new edge in the ack cycle wins.
module rat_irq_prio
  import rat_pkg::*;
#(
  parameter int                 NUM_IRQ   = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_IRQ-1:0]   irq_i,
  input  logic [NUM_IRQ-1:0]   ack_i,
  output logic                 any_pending_o,
  output logic [RAT_IDX_W-1:0] winner_o,
  output logic [NUM_IRQ-1:0]   onehot_o
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] edge_pend_q;
  logic [NUM_IRQ-1:0] edge_pend_d;
  logic [NUM_IRQ-1:0] pending;

  // Edge latch: clear on ack, but a fresh rising edge in the same cycle re-arms it.
  always_comb begin
    edge_pend_d = EDGE_MASK & ((edge_pend_q & ~ack_i) | (irq_i & ~irq_q));
  end

  // History of the request lines and the edge latches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q       <= '0;
      edge_pend_q <= '0;
    end else begin
      irq_q       <= irq_i;
      edge_pend_q <= edge_pend_d;
    end
  end

  assign pending       = (EDGE_MASK & edge_pend_q) | (~EDGE_MASK & irq_i);
  assign any_pending_o = |pending;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    winner_o = '0;
    onehot_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        winner_o    = RAT_IDX_W'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rat_seq.sv
// RAT sequencer: INIT/FETCH/EXEC/IOWAIT/INTRPT with prioritised interrupts and IO wait-states.
// Latency: 2 cycles per instruction, +k IO wait cycles, +1 when an interrupt is taken.
// Backpressure: IO_RDY low stalls in IOWAIT; with RAT_IO_TIMEOUT_EN the stall is capped at WAIT_MAX cycles.
module rat_seq_irq
  import rat_pkg::*;
#(
  parameter int                 NUM_IRQ   = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter int                 PC_W      = 10,
  parameter logic [PC_W-1:0]    VEC_BASE  = PC_W'(RAT_DEFAULT_VEC),
  parameter int                 WAIT_MAX  = 16
) (
  input  logic          CLK,
  input  logic          RESET_N,
  rat_seq_irq_if.master bus
);

  if (WAIT_MAX < 2) begin : g_wait_chk
    $error("rat_seq_irq: WAIT_MAX must be at least 2");
  end
  if (NUM_IRQ < 1 || NUM_IRQ > RAT_MAX_IRQ) begin : g_irq_chk
    $error("rat_seq_irq: NUM_IRQ out of range");
  end

  seq_state_t state_q, state_d;
  logic       iflag_q, iflag_d;
  logic       pc_rst_q, pc_inc_q, intr_q;
  logic       exec_en, io_tmo, take;

  logic                 any_pending;
  logic [RAT_IDX_W-1:0] winner;
  logic [NUM_IRQ-1:0]   winner_oh;
  logic [NUM_IRQ-1:0]   ack;

`ifdef RAT_IO_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_MAX);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  rat_irq_prio #(
    .NUM_IRQ   (NUM_IRQ),
    .EDGE_MASK (EDGE_MASK)
  ) u_prio (
    .clk_i         (CLK),
    .rst_ni        (RESET_N),
    .irq_i         (bus.IRQ),
    .ack_i         (ack),
    .any_pending_o (any_pending),
    .winner_o      (winner),
    .onehot_o      (winner_oh)
  );

  // The decoder's own flag op counts toward the decision made in the same cycle.
  assign take = any_pending & (iflag_q | bus.I_SET) & ~bus.I_CLR;

  // Next-state, final-cycle detection and flag update.
  always_comb begin
    state_d = state_q;
    exec_en = 1'b0;
    io_tmo  = 1'b0;
    iflag_d = iflag_q;
`ifdef RAT_IO_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_EXEC;
      ST_EXEC: begin
        if (bus.IO_REQ && !bus.IO_RDY) begin
          state_d = ST_IOWAIT;
`ifdef RAT_IO_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          exec_en = 1'b1;
        end
      end
      ST_IOWAIT: begin
`ifdef RAT_IO_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (bus.IO_RDY) begin
          exec_en = 1'b1;
`ifdef RAT_IO_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          exec_en = 1'b1;
          io_tmo  = 1'b1;
`endif
        end
      end
      ST_INTRPT: begin
        state_d = ST_FETCH;
        iflag_d = 1'b0;
      end
      default:   state_d = ST_INIT;
    endcase

    if (exec_en) begin
      state_d = take ? ST_INTRPT : ST_FETCH;
      if (bus.I_CLR) begin
        iflag_d = 1'b0;
      end else if (bus.I_SET) begin
        iflag_d = 1'b1;
      end
    end
  end

  // Sequencer state, interrupt-enable flag, wait counter and registered strobes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_INIT;
      iflag_q  <= 1'b0;
      pc_rst_q <= 1'b1;
      pc_inc_q <= 1'b0;
      intr_q   <= 1'b0;
`ifdef RAT_IO_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      iflag_q  <= iflag_d;
      pc_rst_q <= (state_d == ST_INIT);
      pc_inc_q <= (state_d == ST_FETCH);
      intr_q   <= (state_d == ST_INTRPT);
`ifdef RAT_IO_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // The winner is re-evaluated in the entry cycle itself, so ack and vector track it.
  assign ack = intr_q ? winner_oh : '0;

  assign bus.PC_RST      = pc_rst_q;
  assign bus.PC_INC      = pc_inc_q;
  assign bus.EXEC_EN     = exec_en;
  assign bus.INTR_ACTIVE = intr_q;
  assign bus.IRQ_ACK     = ack;
  assign bus.VECTOR      = intr_q ? (VEC_BASE - PC_W'(winner)) : '0;
  assign bus.I_FLAG      = iflag_q;
  assign bus.IO_TIMEOUT  = io_tmo;
  assign bus.STATE       = state_q;

endmodule

// File: doc/rat_seq_irq.md
# rat_seq_irq

Parametrised successor to the RAT control-unit sequencer. It owns the INIT/FETCH/EXEC/INTRPT state machine and adds three things:
- multi-source prioritised interrupts, each source configurable as level or edge, each with its own vector;
- an internal interrupt-enable flag;
- IO wait-states with an optional timeout.

It sits between the opcode decoder and the PC/SP/scratch datapath. The decoder keeps producing per-opcode controls and gates its write-enables with EXEC_EN.

## Interface
- NUM_IRQ, 4, number of interrupt sources (1..16); index 0 is highest priority.
- EDGE_MASK, {NUM_IRQ{1'b0}}, bit i = 1 makes source i edge-triggered, 0 makes it level.
- PC_W, 10, program-counter / vector width.
- VEC_BASE, 10'h3FF, vector of source 0.
- WAIT_MAX, 16, IO wait-state limit in cycles (≥2).
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- IRQ  in  NUM_IRQ  interrupt requests, synchronous to CLK.
- I_SET  in  1  decoder: SEI/RETIE in this EXEC cycle.
- I_CLR  in  1  decoder: CLI/RETID in this EXEC cycle.
- IO_REQ  in  1  decoder: current instruction is IN/OUT.
- IO_RDY  in  1  IO peripheral ready; sampled only in EXEC/IOWAIT.
- PC_RST  out  1  PC reset strobe.
- PC_INC  out  1  PC increment strobe.
- EXEC_EN  out  1  decoder write-enables are valid this cycle.
- INTR_ACTIVE  out  1  interrupt entry cycle (push PC, shadow flags, load VECTOR).
- VECTOR  out  PC_W  vector of the source being serviced.
- IRQ_ACK  out  NUM_IRQ  one-hot acknowledge.
- I_FLAG  out  1  interrupt-enable flag.
- IO_TIMEOUT  out  1  one-cycle pulse when a wait is abandoned.
- STATE  out  3  current state (rat_pkg::seq_state_t).

## Operation
- States: ST_INIT, ST_FETCH, ST_EXEC, ST_IOWAIT, ST_INTRPT.
- ST_INIT:
  - PC_RST=1.
  - Next state is ST_FETCH.
- ST_FETCH:
  - PC_INC=1.
  - Next state is ST_EXEC.
- ST_EXEC:
  - If IO_REQ=1 and IO_RDY=0: EXEC_EN=0, and the next state is ST_IOWAIT with the wait counter cleared.
  - Otherwise this is the final EXEC cycle: EXEC_EN=1, then the interrupt decision is made.
- ST_IOWAIT:
  - EXEC_EN=0 and the counter increments each cycle.
  - When IO_RDY=1, this is the final cycle: EXEC_EN=1.
  - When the counter reaches WAIT_MAX-1 (macro enabled), this is the final cycle: EXEC_EN=1 and IO_TIMEOUT=1.
- Interrupt decision, made in the final cycle:
  - take = any pending & ((I_FLAG | I_SET) & ~I_CLR).
  - take=1: next state is ST_INTRPT. take=0: next state is ST_FETCH.
- ST_INTRPT:
  - INTR_ACTIVE=1.
  - Select the winner = lowest-index pending source; IRQ_ACK[winner]=1; VECTOR = VEC_BASE − winner (mod 2^PC_W).
  - I_FLAG cleared. Next state is ST_FETCH.
- I_FLAG register:
  - Updated only in the final cycle: I_CLR dominates I_SET.
  - Cleared by ST_INTRPT.
- Pending, level source: pending = IRQ[i] as sampled this cycle.
- Pending, edge source:
  - A register set on IRQ[i] & ~IRQ_q[i], cleared by IRQ_ACK[i].
  - If a set and a clear occur in the same cycle, the set wins.
- Outputs not named for a state are 0 in that state. VECTOR is 0 outside ST_INTRPT.
- Illegal STATE encoding goes to ST_INIT.

## Timing
- Reset (asynchronous, any state, including mid-IOWAIT):
  - STATE=ST_INIT, I_FLAG=0, all pending/IRQ_q/counter = 0, all outputs 0 except PC_RST=1.
- First PC_INC occurs 1 cycle after RESET_N deasserts.
- Instruction latency:
  - 2 cycles (FETCH+EXEC).
  - 2+k cycles with k wait cycles.
  - +1 cycle if an interrupt is taken.
- Interrupt latency from an IRQ edge: detected at the next clock, serviced after the current instruction's final cycle.
- IRQ_ACK, INTR_ACTIVE and IO_TIMEOUT are single-cycle pulses.
- IO_RDY is ignored outside ST_EXEC/ST_IOWAIT.

## Configuration
- RAT_IO_TIMEOUT_EN defined:
  - The wait counter and IO_TIMEOUT are present.
  - A wait ends after at most WAIT_MAX cycles in ST_IOWAIT.
- RAT_IO_TIMEOUT_EN undefined:
  - No counter; IO_TIMEOUT is tied to 0.
  - ST_IOWAIT holds until IO_RDY (may stall forever).
  - WAIT_MAX is unused.

## Structure
- rat_pkg holds:
  - typedef enum logic [2:0] seq_state_t;
  - constant RAT_DEFAULT_VEC = 10'h3FF;
  - constant RAT_MAX_IRQ = 16.
- Sub-module rat_irq_prio: edge detect, pending registers, lowest-index priority encoder; outputs any_pending, winner index, and one-hot form.

## Test plan
- Reset release → PC_RST for 1 cycle, then FETCH/EXEC alternating.
- RESET_N low in ST_IOWAIT → immediate ST_INIT, I_FLAG=0.
- NUM_IRQ=4, EDGE_MASK=4'b0010, I_FLAG=1, IRQ=4'b0110 rising together → service 1 first: VECTOR=0x3FE, IRQ_ACK=0010, I_FLAG=0. After RETIE, source 2 (still high) is serviced with VECTOR=0x3FD.
- I_SET and I_CLR both high in the final cycle with an IRQ pending → no ST_INTRPT, I_FLAG=0.
- IO_REQ=1, IO_RDY low for 3 cycles then high → EXEC_EN low for 3 cycles then high, IO_TIMEOUT=0.
- RAT_IO_TIMEOUT_EN defined, WAIT_MAX=4, IO_RDY held low → EXEC_EN and IO_TIMEOUT high together on the 4th ST_IOWAIT cycle, then ST_FETCH. The same stimulus without the macro → stays in ST_IOWAIT.
